// File: rtl/np_pkg.sv
// Shared constants for the np core and its memory-side responder.
// Word/address sizes, opcodes and responder FSM state encoding.
package np_pkg;

   localparam int WIDTH    = 32;
   localparam int ADDRSIZE = 12;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_LDI  = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_HLT  = 4'hB;

   localparam logic [1:0] ST_LOAD    = 2'b00;
   localparam logic [1:0] ST_RELEASE = 2'b01;
   localparam logic [1:0] ST_RUN     = 2'b10;
   localparam logic [1:0] ST_HALTED  = 2'b11;

endpackage

// File: rtl/np_ram_1w2r.sv
// Single-write, dual asynchronous-read word array.
// Contents are never reset; reads are combinational.
module np_ram_1w2r
   import np_pkg::*;
#(
   parameter int W  = WIDTH,
   parameter int AW = ADDRSIZE
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr0,
   output logic [W-1:0]  rdata0,
   input  logic [AW-1:0] raddr1,
   output logic [W-1:0]  rdata1
);

   logic [W-1:0] mem [0:(1<<AW)-1];

   // Single synchronous write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/np_mem_responder.sv
// Memory-side responder for the np core: program loader, imem/dmem,
// core reset sequencing, halt capture, debug port and cycle counter.
module np_mem_responder
   import np_pkg::*;
#(
   parameter int WIDTH    = np_pkg::WIDTH,
   parameter int ADDRSIZE = np_pkg::ADDRSIZE,
   parameter int DEPTH    = 1 << ADDRSIZE,
   parameter int CNTW     = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [WIDTH-1:0]    ld_data,
   input  logic                ld_last,
   output logic                cpu_reset,
   input  logic [ADDRSIZE-1:0] i_addr,
   input  logic                i_wr,
   output logic [WIDTH-1:0]    i_rdata,
   input  logic [ADDRSIZE-1:0] d_addr,
   input  logic                d_wr,
   input  logic [WIDTH-1:0]    d_wdata,
   output logic [WIDTH-1:0]    d_rdata,
   input  logic                cpu_halt,
   input  logic [ADDRSIZE-1:0] dbg_addr,
   output logic [WIDTH-1:0]    dbg_rdata,
   output logic [ADDRSIZE:0]   load_count,
   output logic [CNTW-1:0]     run_cycles,
   output logic                done,
   output logic                err
);

   localparam logic [ADDRSIZE:0] LAST_IDX = (ADDRSIZE+1)'(DEPTH - 1);

   logic [1:0]       state;
   logic             in_load;
   logic             in_run;
   logic             in_halt;
   logic             xfer;
   logic             load_end;
   logic             d_we;
   logic             err_set;
   logic [WIDTH-1:0] imem_unused;

   assign in_load  = (state == ST_LOAD);
   assign in_run   = (state == ST_RUN);
   assign in_halt  = (state == ST_HALTED);

   assign ld_ready  = in_load && !reset;
   assign cpu_reset = !in_run;
   assign done      = in_halt;

   assign xfer     = ld_valid && ld_ready;
   assign load_end = xfer && (ld_last || load_count == LAST_IDX);
   assign d_we     = in_run && d_wr && !reset;
   assign err_set  = (in_run && (i_wr || ld_valid))
                  || (in_halt && d_wr);

   // Responder sequencing: load program, pulse core reset, run, halt.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_LOAD;
      end else begin
         case (state)
            ST_LOAD:    if (load_end) state <= ST_RELEASE;
            ST_RELEASE: state <= ST_RUN;
            ST_RUN:     if (cpu_halt) state <= ST_HALTED;
            ST_HALTED:  state <= ST_HALTED;
            default:    state <= ST_LOAD;
         endcase
      end
   end

   // Loader write pointer; never exceeds DEPTH since the last slot ends LOAD.
   always_ff @(posedge clk) begin
      if (reset) load_count <= '0;
      else if (xfer) load_count <= load_count + (ADDRSIZE+1)'(1);
   end

   // Saturating count of cycles spent in RUN.
   always_ff @(posedge clk) begin
      if (reset) run_cycles <= '0;
      else if (in_run && run_cycles != '1)
         run_cycles <= run_cycles + CNTW'(1);
   end

   // Sticky protocol error flag.
   always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

   np_ram_1w2r #(.W(WIDTH), .AW(ADDRSIZE)) u_imem (
      .clk    (clk),
      .we     (xfer),
      .waddr  (load_count[ADDRSIZE-1:0]),
      .wdata  (ld_data),
      .raddr0 (i_addr),
      .rdata0 (i_rdata),
      .raddr1 (i_addr),
      .rdata1 (imem_unused)
   );

   np_ram_1w2r #(.W(WIDTH), .AW(ADDRSIZE)) u_dmem (
      .clk    (clk),
      .we     (d_we),
      .waddr  (d_addr),
      .wdata  (d_wdata),
      .raddr0 (d_addr),
      .rdata0 (d_rdata),
      .raddr1 (dbg_addr),
      .rdata1 (dbg_rdata)
   );

endmodule

// File: tb/tb_np_mem_responder.sv
// Directed self-checking bench for np_mem_responder.
// Inputs change and outputs are sampled around the falling edge.
module tb_np_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [31:0] ld_data = '0;
   logic        ld_last = 1'b0;
   logic        cpu_reset;
   logic [11:0] i_addr = '0;
   logic        i_wr = 1'b0;
   logic [31:0] i_rdata;
   logic [11:0] d_addr = '0;
   logic        d_wr = 1'b0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        cpu_halt = 1'b0;
   logic [11:0] dbg_addr = '0;
   logic [31:0] dbg_rdata;
   logic [12:0] load_count;
   logic [31:0] run_cycles;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   np_mem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .cpu_reset  (cpu_reset),
      .i_addr     (i_addr),
      .i_wr       (i_wr),
      .i_rdata    (i_rdata),
      .d_addr     (d_addr),
      .d_wr       (d_wr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .cpu_halt   (cpu_halt),
      .dbg_addr   (dbg_addr),
      .dbg_rdata  (dbg_rdata),
      .load_count (load_count),
      .run_cycles (run_cycles),
      .done       (done),
      .err        (err)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ld_valid = 1'b0; ld_last = 1'b0;
      i_wr = 1'b0; d_wr = 1'b0; cpu_halt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w, input logic last);
      @(negedge clk);
      ld_valid = 1'b1; ld_data = w; ld_last = last;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ld_ready got %b want 0", ld_ready);
      end
      checks++;
      if (cpu_reset !== 1'b1) begin
         errors++;
         $display("FAIL rst_cpu_reset got %b want 1", cpu_reset);
      end
      checks++;
      if ({load_count, run_cycles, done, err} !== '0) begin
         errors++;
         $display("FAIL rst_regs got lc=%0d rc=%0d done=%b err=%b want zeros",
                  load_count, run_cycles, done, err);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_exit_ld_ready got %b want 1", ld_ready);
      end
   endtask

   task automatic test_full();
      do_reset();
      ld_valid = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         ld_data = 32'h5A00_0000 ^ i;
         @(negedge clk);
      end
      ld_valid = 1'b0;
      #1;
      checks++;
      if (load_count !== 13'd4096) begin
         errors++;
         $display("FAIL full_count got %0d want 4096", load_count);
      end
      checks++;
      if (ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready got %b want 0", ld_ready);
      end
      i_addr = 12'hFFF;
      #1;
      checks++;
      if (i_rdata !== 32'h5A00_0FFF) begin
         errors++;
         $display("FAIL full_last_word got %h want 5a000fff", i_rdata);
      end
      i_addr = 12'h000;
      #1;
      checks++;
      if (i_rdata !== 32'h5A00_0000) begin
         errors++;
         $display("FAIL full_first_word got %h want 5a000000", i_rdata);
      end
   endtask

   task automatic test_load_basic();
      do_reset();
      load_word(32'h3100_0005, 1'b0);
      load_word(32'h4100_0001, 1'b0);
      load_word(32'hB000_0000, 1'b1);
      #1;
      checks++;
      if (load_count !== 13'd3) begin
         errors++;
         $display("FAIL basic_count got %0d want 3", load_count);
      end
      checks++;
      if (cpu_reset !== 1'b1 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_release got rst=%b rdy=%b want rst=1 rdy=0",
                  cpu_reset, ld_ready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (cpu_reset !== 1'b0) begin
         errors++;
         $display("FAIL basic_run_rst got %b want 0", cpu_reset);
      end
      i_addr = 12'd1;
      #1;
      checks++;
      if (i_rdata !== 32'h4100_0001) begin
         errors++;
         $display("FAIL basic_fetch1 got %h want 41000001", i_rdata);
      end
      i_addr = 12'd2;
      #1;
      checks++;
      if (i_rdata !== 32'hB000_0000) begin
         errors++;
         $display("FAIL basic_fetch2 got %h want b0000000", i_rdata);
      end
   endtask

   task automatic test_load_toggle();
      logic [31:0] w [4];
      w[0] = 32'h1111_0000; w[1] = 32'h2222_0001;
      w[2] = 32'h3333_0002; w[3] = 32'h4444_0003;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 3);
         @(negedge clk);
         ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'hBAD0_0000 | i;
      end
      #1;
      checks++;
      if (load_count !== 13'd4 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL toggle_end got lc=%0d rdy=%b want lc=4 rdy=0",
                  load_count, ld_ready);
      end
      for (int i = 0; i < 4; i++) begin
         i_addr = 12'(i);
         #1;
         checks++;
         if (i_rdata !== w[i]) begin
            errors++;
            $display("FAIL toggle_imem%0d got %h want %h", i, i_rdata, w[i]);
         end
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      d_wr = 1'b1; d_addr = 12'h010; d_wdata = 32'h1111_1111;
      dbg_addr = 12'h010;
      @(negedge clk);
      d_wdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (dbg_rdata !== 32'h1111_1111) begin
         errors++;
         $display("FAIL store_dbg_old got %h want 11111111", dbg_rdata);
      end
      @(negedge clk);
      d_wr = 1'b0;
      #1;
      checks++;
      if (d_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL store_d_rdata got %h want deadbeef", d_rdata);
      end
      checks++;
      if (dbg_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL store_dbg got %h want deadbeef", dbg_rdata);
      end
   endtask

   task automatic test_halt();
      do_reset();
      dbg_addr = 12'h010;
      #1;
      checks++;
      if (dbg_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL halt_mem_kept got %h want deadbeef", dbg_rdata);
      end
      load_word(32'hB000_0000, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (run_cycles !== 32'd0 || cpu_reset !== 1'b0) begin
         errors++;
         $display("FAIL halt_run_start got rc=%0d rst=%b want rc=0 rst=0",
                  run_cycles, cpu_reset);
      end
      repeat (9) @(negedge clk);
      cpu_halt = 1'b1;
      d_wr = 1'b1; d_addr = 12'h020; d_wdata = 32'h5;
      @(negedge clk);
      cpu_halt = 1'b0; d_wr = 1'b0;
      dbg_addr = 12'h020;
      #1;
      checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b1 || run_cycles !== 32'd10) begin
         errors++;
         $display("FAIL halt_state got done=%b rst=%b rc=%0d want 1 1 10",
                  done, cpu_reset, run_cycles);
      end
      checks++;
      if (dbg_rdata !== 32'h5 || err !== 1'b0) begin
         errors++;
         $display("FAIL halt_store got %h err=%b want 00000005 err=0",
                  dbg_rdata, err);
      end
      d_wr = 1'b1; d_wdata = 32'h7;
      @(negedge clk);
      d_wr = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (dbg_rdata !== 32'h5 || err !== 1'b1) begin
         errors++;
         $display("FAIL halt_blocked got %h err=%b want 00000005 err=1",
                  dbg_rdata, err);
      end
      checks++;
      if (run_cycles !== 32'd10 || done !== 1'b1) begin
         errors++;
         $display("FAIL halt_frozen got rc=%0d done=%b want 10 1",
                  run_cycles, done);
      end
   endtask

   task automatic test_err();
      do_reset();
      load_word(32'hAAAA_0001, 1'b1);
      @(negedge clk);
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clean got %b want 0", err);
      end
      i_addr = 12'd0; i_wr = 1'b1;
      @(negedge clk);
      i_wr = 1'b0;
      #1;
      checks++;
      if (err !== 1'b1 || i_rdata !== 32'hAAAA_0001) begin
         errors++;
         $display("FAIL err_iwr got err=%b imem0=%h want 1 aaaa0001",
                  err, i_rdata);
      end
      do_reset();
      load_word(32'hAAAA_0002, 1'b1);
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 32'h1234_5678;
      @(negedge clk);
      ld_valid = 1'b0;
      i_addr = 12'd1;
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (err !== 1'b1 || load_count !== 13'd1) begin
         errors++;
         $display("FAIL err_ldv got err=%b lc=%0d want 1 1", err, load_count);
      end
      checks++;
      if (i_rdata !== 32'h2222_0001) begin
         errors++;
         $display("FAIL err_imem1 got %h want 22220001", i_rdata);
      end
      do_reset();
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_cleared got %b want 0", err);
      end
   endtask

   task automatic test_reload();
      do_reset();
      load_word(32'hC0DE_0000, 1'b0);
      load_word(32'hC0DE_0001, 1'b0);
      do_reset();
      load_word(32'hF00D_0000, 1'b1);
      #1;
      checks++;
      if (load_count !== 13'd1) begin
         errors++;
         $display("FAIL reload_count got %0d want 1", load_count);
      end
      i_addr = 12'd0;
      #1;
      checks++;
      if (i_rdata !== 32'hF00D_0000) begin
         errors++;
         $display("FAIL reload_imem0 got %h want f00d0000", i_rdata);
      end
      i_addr = 12'd1;
      #1;
      checks++;
      if (i_rdata !== 32'hC0DE_0001) begin
         errors++;
         $display("FAIL reload_imem1 got %h want c0de0001", i_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_load_basic();
      test_store();
      test_load_toggle();
      test_halt();
      test_err();
      test_reload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/np_mem_responder.md
Name: np_mem_responder

Overview:
- Memory-side responder for the non-pipelined RISC core (np).
- Owns the 4096x32 instruction memory and the 4096x32 data memory, and answers the core's fetch and load/store bus.
- Provides a valid/ready program-loader stream that fills instruction memory while holding the core in reset, then releases the core.
- Captures halt, freezes memory, and exposes a debug read port and a run-cycle counter for the testbench.

Parameters:
- WIDTH, 32, data/instruction word width
- ADDRSIZE, 12, address width of both memories
- DEPTH, 1<<ADDRSIZE, words per memory
- CNTW, 32, run-cycle counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader may accept
- ld_data  in  WIDTH  loader instruction word
- ld_last  in  1  final word of program
- cpu_reset  out  1  reset to core
- i_addr  in  ADDRSIZE  core fetch address
- i_wr  in  1  core fetch-port write strobe (illegal when 1)
- i_rdata  out  WIDTH  fetched instruction
- d_addr  in  ADDRSIZE  core data address
- d_wr  in  1  1=store, 0=load
- d_wdata  in  WIDTH  store data
- d_rdata  out  WIDTH  load data
- cpu_halt  in  1  core halt indication
- dbg_addr  in  ADDRSIZE  debug data-memory read address
- dbg_rdata  out  WIDTH  debug read data
- load_count  out  ADDRSIZE+1  words loaded
- run_cycles  out  CNTW  cycles spent in RUN
- done  out  1  core halted
- err  out  1  sticky protocol error

Behaviour:
- States: LOAD, RELEASE, RUN, HALTED.
- Reset values: state=LOAD, ld_ready=0 for the reset cycle, cpu_reset=1, load_count=0, run_cycles=0, done=0, err=0.
- Reset does not clear either memory.
- Read timing: i_rdata=imem[i_addr], d_rdata=dmem[d_addr] and dbg_rdata=dmem[dbg_addr] are all combinational, with zero latency. The core samples them within the same state.
- LOAD:
  - ld_ready=1 and cpu_reset=1.
  - Transfer occurs when ld_valid&ld_ready at posedge: imem[load_count]<=ld_data, then load_count++.
  - Transfer with ld_last=1, or transfer writing address DEPTH-1, moves to RELEASE. In that case ld_ready=0 the next cycle.
  - ld_valid=0 means hold; there is no timeout.
  - While in LOAD, d_wr and i_wr are ignored.
- RELEASE: one cycle with cpu_reset=1 and ld_ready=0, then go to RUN. This guarantees the core sees at least one reset edge after the final imem write.
- RUN:
  - cpu_reset=0 and ld_ready=0.
  - d_wr=1 at posedge writes dmem[d_addr]<=d_wdata. The write is visible on d_rdata/dbg_rdata in the following cycle.
  - run_cycles increments every RUN cycle and saturates at all-ones.
  - i_wr=1 does not modify imem and sets err.
  - ld_valid=1 sets err; the word is dropped.
  - cpu_halt=1 at posedge moves to HALTED. A d_wr asserted in that same cycle is still performed.
- HALTED:
  - done=1 and cpu_reset=1.
  - All writes are blocked; a d_wr sets err.
  - run_cycles is frozen; the debug port remains live.
  - Only reset exits this state.
- Reset mid-load: load_count returns to 0 and loading restarts at address 0. Previously written words persist until overwritten.
- err is sticky and is cleared only by reset.
- Simultaneous d_wr and dbg_addr==d_addr: dbg_rdata shows the old value in that cycle.
- Address wrap: none. Loads are capped at DEPTH words (load_count max = DEPTH).

Decomposition:
- Shared package np_pkg holds:
  - WIDTH, ADDRSIZE
  - opcode constants (NOP..HLT)
  - state encoding for this block's FSM: LOAD=2'b00, RELEASE=2'b01, RUN=2'b10, HALTED=2'b11
- One natural sub-module, np_ram_1w2r: a single-write, two-async-read DEPTHxWIDTH array.
  - One instance for imem; its second read port is unused.
  - One instance for dmem, serving the d_rdata and dbg_rdata read ports.
- The FSM, counters and err logic live in the top.

Test Plan:
1. Load 3 words (0x3100_0005, 0x4100_0001, 0xB000_0000) with ld_last on the third -> load_count=3; cpu_reset drops exactly 2 cycles after the last transfer; i_addr=1 yields 0x4100_0001.
2. Loader with ld_valid toggling every other cycle over 4 words -> only handshaken words are written; imem[0..3] correct; ld_ready=0 after the last word.
3. In RUN, d_wr=1, d_addr=0x010, d_wdata=0xDEAD_BEEF, then d_wr=0 -> d_rdata at 0x010 reads 0xDEADBEEF the next cycle; dbg_addr=0x010 matches.
4. Assert cpu_halt after 10 RUN cycles with a simultaneous store of 0x5 to 0x020 -> done=1, run_cycles=10, dmem[0x020]=5; a later d_wr to 0x020 leaves 5 and sets err.
5. i_wr=1 in RUN, and separately ld_valid=1 in RUN -> err=1; imem unchanged; err persists until reset.
6. reset after 2 of 5 loaded words, then reload 1 word with ld_last -> load_count=1; imem[0] is the new word; imem[1] retains the old word.
